// File: rtl/rgbw_spi_master.sv
// rgbw_spi_master: SPI mode-0 master that streams one CS-low frame of
// FRAME_BYTES bytes, pulling each byte through a valid/ready handshake.
// Parameters:
//   CLK_DIV     - SCK half-period in clk cycles (1..255)
//   FRAME_BYTES - bytes per CS-low frame (1..15)
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   start, abort        - frame request (IDLE only) / immediate termination
//   tx_data, tx_valid   - next byte (MSB first) and its qualifier
//   tx_ready            - byte accepted on any edge with tx_valid & tx_ready
//   sck, mosi, cs       - SPI clock (CPOL=0), serial data, active-low select
//   busy, done          - not-IDLE indicator, one-cycle frame-complete pulse
module rgbw_spi_master #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned FRAME_BYTES = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       sck,
    output logic       mosi,
    output logic       cs,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BYTE_W = 4;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTES_LAST = BYTE_W'(FRAME_BYTES);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [BIT_W-1:0]    r_bit;
    logic [BYTE_W-1:0]   r_byte;
    logic [DATA_W-1:0]   r_shift;
    logic                r_sck;
    logic                r_cs;
    logic                r_tx_ready;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [DIV_W-1:0]    w_div_nxt;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic [BYTE_W-1:0]   w_byte_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                w_sck_nxt;
    logic                w_cs_nxt;
    logic                w_tx_ready_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    logic                w_div_zero;
    logic [DIV_W-1:0]    w_div_dec;
    logic [BYTE_W-1:0]   w_byte_inc;
    logic [BIT_W-1:0]    w_bit_inc;
    logic                w_accept;

    assign w_div_zero = (r_div == '0);
    assign w_div_dec  = r_div - DIV_W'(1);
    assign w_byte_inc = r_byte + BYTE_W'(1);
    assign w_bit_inc  = r_bit + BIT_W'(1);
    assign w_accept   = tx_valid && r_tx_ready;

    // State and datapath registers; reset overrides every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_byte     <= '0;
            r_shift    <= '0;
            r_sck      <= 1'b0;
            r_cs       <= 1'b1;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_bit      <= w_bit_nxt;
            r_byte     <= w_byte_nxt;
            r_shift    <= w_shift_nxt;
            r_sck      <= w_sck_nxt;
            r_cs       <= w_cs_nxt;
            r_tx_ready <= w_tx_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_bit_nxt      = r_bit;
        w_byte_nxt     = r_byte;
        w_shift_nxt    = r_shift;
        w_sck_nxt      = r_sck;
        w_cs_nxt       = r_cs;
        w_tx_ready_nxt = 1'b0;
        w_done_nxt     = 1'b0;

        if (abort) begin
            // Abort wins everywhere, including over start in IDLE; the
            // partially shifted byte is dropped with the shift register.
            w_state_nxt = ST_IDLE;
            w_div_nxt   = '0;
            w_bit_nxt   = '0;
            w_byte_nxt  = '0;
            w_shift_nxt = '0;
            w_sck_nxt   = 1'b0;
            w_cs_nxt    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cs_nxt  = 1'b1;
                    w_sck_nxt = 1'b0;
                    if (start) begin
                        w_state_nxt = ST_SETUP;
                        w_cs_nxt    = 1'b0;
                        w_div_nxt   = DIV_RELOAD;
                        w_byte_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_shift_nxt = '0;
                    end
                end

                ST_SETUP: begin
                    if (w_div_zero) begin
                        w_state_nxt    = ST_LOAD;
                        w_tx_ready_nxt = 1'b1;
                    end else begin
                        w_div_nxt = w_div_dec;
                    end
                end

                // Stall here with sck low until a byte is offered.
                ST_LOAD: begin
                    if (w_accept) begin
                        w_state_nxt = ST_SHIFT;
                        w_shift_nxt = tx_data;
                        w_div_nxt   = DIV_RELOAD;
                        w_bit_nxt   = '0;
                        w_sck_nxt   = 1'b0;
                    end else begin
                        w_tx_ready_nxt = 1'b1;
                    end
                end

                // Low half then high half per bit; data moves only on the fall.
                ST_SHIFT: begin
                    if (!w_div_zero) begin
                        w_div_nxt = w_div_dec;
                    end else if (!r_sck) begin
                        w_sck_nxt = 1'b1;
                        w_div_nxt = DIV_RELOAD;
                    end else begin
                        w_sck_nxt   = 1'b0;
                        w_div_nxt   = DIV_RELOAD;
                        w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
                        if (r_bit == BIT_LAST) begin
                            w_bit_nxt  = '0;
                            w_byte_nxt = w_byte_inc;
                            if (w_byte_inc == BYTES_LAST) begin
                                w_state_nxt = ST_HOLD;
                            end else begin
                                w_state_nxt    = ST_LOAD;
                                w_tx_ready_nxt = 1'b1;
                            end
                        end else begin
                            w_bit_nxt = w_bit_inc;
                        end
                    end
                end

                ST_HOLD: begin
                    if (w_div_zero) begin
                        w_state_nxt = ST_GAP;
                        w_cs_nxt    = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_div_nxt   = DIV_RELOAD;
                    end else begin
                        w_div_nxt = w_div_dec;
                    end
                end

                // Guaranteed cs-high time between frames; start is ignored.
                ST_GAP: begin
                    w_cs_nxt  = 1'b1;
                    w_sck_nxt = 1'b0;
                    if (w_div_zero) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_div_nxt = w_div_dec;
                    end
                end

                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cs_nxt    = 1'b1;
                    w_sck_nxt   = 1'b0;
                    w_shift_nxt = '0;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign tx_ready = r_tx_ready;
    assign sck      = r_sck;
    assign mosi     = r_shift[DATA_W-1];
    assign cs       = r_cs;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_rgbw_spi_master.sv
// tb_rgbw_spi_master: randomized frames checked against timing derived from
// the half-period arithmetic and a queue of accepted bytes.
module tb_rgbw_spi_master;

    localparam int unsigned D      = 2;
    localparam int unsigned FB     = 4;
    localparam int          BUDGET = 4000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       sck;
    logic       mosi;
    logic       cs;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    rgbw_spi_master #(
        .CLK_DIV     (D),
        .FRAME_BYTES (FB)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .sck      (sck),
        .mosi     (mosi),
        .cs       (cs),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One full frame with optional LOAD stall after byte stall_after.
    task automatic do_frame(input int stall_after, input int stall_len, input bit gap_start,
                            input bit fixed_first, input logic [7:0] first_byte);
        logic [7:0] bytes [FB];
        logic [7:0] sent [$];
        logic [7:0] got [$];
        logic [7:0] shreg;
        logic       prev_sck, prev_mosi, acc;
        int t0, idx, rises, first_rise, last_acc, done_cyc, nbits;
        int cs_high, mosi_bad, stall_bad, stall_left, exp_gap;

        for (int i = 0; i < FB; i++) bytes[i] = 8'($urandom);
        if (fixed_first) bytes[0] = first_byte;
        idx = 0; rises = 0; first_rise = -1; last_acc = -1; done_cyc = -1; nbits = 0;
        cs_high = 0; mosi_bad = 0; stall_bad = 0; stall_left = 0; shreg = '0;
        exp_gap = 16 * D + 1;

        tx_data = bytes[0]; tx_valid = 1'b1; start = 1'b1;
        tick();
        t0 = cyc; start = 1'b0;
        check("cs_fall", {cs, busy}, 2'b01);
        prev_sck = sck; prev_mosi = mosi;

        for (int n = 0; n < BUDGET && done_cyc < 0; n++) begin
            acc = tx_ready && tx_valid;
            tick();
            if (acc) begin
                if (idx == 0) check("first_accept", cyc - t0, D + 1);
                else check("accept_gap", cyc - last_acc, exp_gap);
                exp_gap = 16 * D + 1;
                last_acc = cyc;
                sent.push_back(bytes[idx]);
                idx++;
                if (idx == stall_after) begin
                    tx_valid = 1'b0; stall_left = stall_len;
                    exp_gap = 16 * D + stall_len;
                end
                tx_data = (idx < FB) ? bytes[idx] : 8'($urandom);
            end
            if (!prev_sck && sck) begin
                rises++;
                if (first_rise < 0) first_rise = cyc;
                if (mosi !== prev_mosi) mosi_bad++;
                shreg = {shreg[6:0], mosi};
                nbits++;
                if (nbits == 8) begin got.push_back(shreg); nbits = 0; end
            end else if (mosi !== prev_mosi && !(prev_sck && !sck) && !acc) begin
                mosi_bad++;
            end
            if (stall_left > 0 && !tx_valid && tx_ready) begin
                if (sck || cs) stall_bad++;
                stall_left--;
                if (stall_left == 0) tx_valid = 1'b1;
            end
            if (done) begin
                done_cyc = cyc;
                check("cs_at_done", cs, 1'b1);
            end else if (cs) begin
                cs_high++;
            end
            prev_sck = sck; prev_mosi = mosi;
        end

        if (done_cyc < 0) begin
            check("frame_timeout", 0, 1);
            return;
        end
        check("first_rise", first_rise - t0, 2 * D + 1);
        check("rise_count", rises, 8 * FB);
        check("byte_count", got.size(), FB);
        for (int i = 0; i < FB && i < int'(got.size()); i++) check("byte_data", got[i], sent[i]);
        check("done_latency", done_cyc - last_acc, 17 * D);
        check("cs_held_low", cs_high, 0);
        check("mosi_stable", mosi_bad, 0);
        check("stall_quiet", stall_bad, 0);

        // GAP: busy stays up for D cycles after done; start there is ignored.
        if (gap_start) start = 1'b1;
        begin
            int extra_done;
            extra_done = 0;
            for (int k = 1; k <= int'(D); k++) begin
                tick();
                if (done) extra_done++;
                check("gap_busy", busy, (k < int'(D)) ? 1'b1 : 1'b0);
                check("gap_cs", cs, 1'b1);
            end
            start = 1'b0;
            tick(); tick();
            if (done) extra_done++;
            check("gap_start_ignored", {cs, busy}, 2'b10);
            check("single_done", extra_done, 0);
        end
    endtask

    // Start a frame and run until byte byte_no has shown n_rises sck rises.
    task automatic run_until(input int byte_no, input int n_rises, output int seen);
        int accs;
        logic prev_sck;
        accs = 0; seen = 0;
        tx_data = 8'($urandom); tx_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        prev_sck = sck;
        for (int n = 0; n < BUDGET && seen < n_rises; n++) begin
            if (tx_ready && tx_valid) begin accs++; tx_data = 8'($urandom); end
            tick();
            if (!prev_sck && sck && accs == byte_no) seen++;
            prev_sck = sck;
        end
    endtask

    task automatic quiet_check(input string tag, input int n);
        int bad;
        logic prev_sck;
        bad = 0; prev_sck = sck;
        for (int k = 0; k < n; k++) begin
            tick();
            if (done || (sck && !prev_sck) || !cs || busy || tx_ready) bad++;
            prev_sck = sck;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        int seen;
        reset = 1'b1; start = 1'b0; abort = 1'b0; tx_data = '0; tx_valid = 1'b0;
        tick(); tick(); tick();
        check("reset_state", {cs, sck, mosi, tx_ready, busy, done}, 6'b100000);
        reset = 1'b0;
        tick();

        do_frame(0, 0, 1'b0, 1'b1, 8'hA5);
        do_frame(3, 20, 1'b1, 1'b0, 8'h00);
        for (int f = 0; f < 4; f++) begin
            do_frame(int'($urandom_range(0, FB - 1)), int'($urandom_range(1, 25)),
                     1'($urandom), 1'b0, 8'h00);
        end

        // Abort after the third sck rise of byte 2.
        run_until(2, 3, seen);
        check("abort_reach", seen, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0; tx_valid = 1'b0;
        check("abort_outs", {cs, sck, mosi, tx_ready, busy, done}, 6'b100000);
        quiet_check("abort_quiet", 40);
        do_frame(0, 0, 1'b0, 1'b0, 8'h00);

        // Reset with abort mid-shift.
        run_until(1, 5, seen);
        check("reset_reach", seen, 5);
        reset = 1'b1; abort = 1'b1;
        tick();
        reset = 1'b0; abort = 1'b0; tx_valid = 1'b0;
        check("reset_mid_outs", {cs, sck, mosi, tx_ready, busy, done}, 6'b100000);
        quiet_check("reset_quiet", 40);
        do_frame(2, 5, 1'b0, 1'b0, 8'h00);

        // start together with abort in IDLE never starts a frame.
        start = 1'b1; abort = 1'b1; tx_valid = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {cs, busy}, 2'b10);
        quiet_check("start_abort_quiet", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rgbw_spi_master.md
RGBW_SPI_MASTER -- requirements
Module: rgbw_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter FRAME_BYTES, default 7: bytes per CS-low frame (lamp frame is lint, R, G, B, W, colorIdx, mode), legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, rising edge, the only clock in the block.
REQ-004 SHALL have port reset, input, 1 bit: synchronous reset, active-high.
REQ-005 SHALL have port start, input, 1 bit: frame request, sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1 bit: terminate the frame immediately.
REQ-007 SHALL have port tx_data, input, 8 bits: next byte to send, MSB first.
REQ-008 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-009 SHALL have port tx_ready, output, 1 bit: block accepts tx_data this cycle.
REQ-010 SHALL have port sck, output, 1 bit: SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-011 SHALL have port mosi, output, 1 bit: serial data.
REQ-012 SHALL have port cs, output, 1 bit: chip select, active-low.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-015 SHALL implement states IDLE, SETUP, LOAD, SHIFT, HOLD and GAP; all outputs SHALL be registered.
REQ-016 IDLE: cs=1, sck=0, mosi=0, tx_ready=0; start=1 at edge T SHALL give cs=0 from T+1 and enter SETUP.
REQ-017 SETUP: SHALL last CLK_DIV cycles with cs=0 and sck=0, then enter LOAD.
REQ-018 LOAD: tx_ready=1 and sck=0; the byte transfers on any edge with tx_valid=1 and tx_ready=1, tx_data loads the shift register, and the state becomes SHIFT.
REQ-019 LOAD with tx_valid=0: SHALL stall indefinitely with cs=0 and sck=0; there is no timeout.
REQ-020 SHIFT: mosi SHALL present bit 7 from the cycle after acceptance.
REQ-021 SHIFT: each bit SHALL be sck low for CLK_DIV cycles, then sck high for CLK_DIV cycles.
REQ-022 SHIFT: mosi SHALL change only on the cycle sck falls (or on entry), so it is stable across every rising edge.
REQ-023 SHIFT: after the 8th high phase, sck SHALL return to 0 and the byte counter SHALL increment.
REQ-024 After each byte: counter < FRAME_BYTES SHALL go to LOAD; counter == FRAME_BYTES SHALL go to HOLD.
REQ-025 Back-to-back bytes (tx_valid held high) SHALL take exactly 16*CLK_DIV+1 cycles per byte, accept edge to accept edge.
REQ-026 HOLD: cs=0 and sck=0 for CLK_DIV cycles, then cs=1, done=1 for exactly one cycle, and the state becomes GAP.
REQ-027 GAP: cs=1 for CLK_DIV cycles, start SHALL be ignored, then the state becomes IDLE; minimum cs-high time between frames is CLK_DIV+1 cycles.
REQ-028 start SHALL be ignored outside IDLE; tx_valid SHALL be ignored outside LOAD.
REQ-029 abort=1 in any non-IDLE state SHALL give cs=1, sck=0, mosi=0, tx_ready=0 on the next cycle and enter IDLE.
REQ-030 An aborted frame SHALL NOT pulse done, and the partial byte SHALL be discarded.
REQ-031 abort and start together in IDLE: abort SHALL win and no frame SHALL start.
REQ-032 The byte counter SHALL be 4 bits and cleared on frame start; the half-period counter SHALL be 8 bits and reloaded on every phase change.
REQ-033 The shift register SHALL shift left with 0 fill.
REQ-034 In IDLE and GAP, sck SHALL be 0 and cs SHALL be 1.

Reset
REQ-035 reset=1 SHALL override every input including abort, forcing IDLE, cs=1, sck=0, mosi=0, tx_ready=0, busy=0, done=0, and all counters and the shift register to 0, at the next clk edge.
REQ-036 reset mid-frame SHALL behave as abort: no done pulse, no partial-byte completion, and no further sck edges after the reset edge.

Verification
REQ-037 CLK_DIV=2, FRAME_BYTES=1, start at T, tx_valid held with 0xA5 -> cs falls T+1, first sck rise T+6, exactly 8 sck rises sampling 1,0,1,0,0,1,0,1, done=1 once, cs high again.
REQ-038 CLK_DIV=1, FRAME_BYTES=7, bytes 0x10..0x16 streamed -> 56 sck rises, accepts exactly 17 cycles apart, cs low continuously, one done pulse.
REQ-039 tx_valid withheld 20 cycles after the 3rd byte -> sck stays 0 and cs stays 0 throughout, then the frame resumes with the 4th byte intact.
REQ-040 abort asserted after the 3rd sck rise of byte 2 -> next cycle cs=1, sck=0, busy=0, no done; a new start succeeds normally.
REQ-041 reset pulsed mid-SHIFT with abort also high -> all outputs at reset values next cycle.
REQ-042 start asserted during GAP -> ignored; start asserted in IDLE with abort=1 -> no frame.
